// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with one fixed 7-bit address, no clock stretching.
// SCL/SDA are oversampled on i_clk (>= 16x SCL). START/STOP are detected in
// every state and override bit processing. SDA is open-drain: pulled low or
// released, never driven high. The bus is expected to carry a pull-up, so a
// released line reads as 1.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   io_scl      I2C clock, observed only
//   io_sda      I2C data, driven 0 or released
//   o_rx_byte   last byte written by the master
//   o_rx_valid  one-cycle pulse when o_rx_byte updates
//   i_tx_byte   byte returned on the next read byte, sampled on load only
//   o_tx_req    one-cycle pulse requesting the next i_tx_byte
//   o_busy      high while addressed, from address ACK until STOP/START
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | SDA released, waiting for START
// ST_ADDR      | shifting 7 address bits + R/W
// ST_ADDR_ACK  | holding address ACK low through the 9th clock
// ST_WRITE     | shifting a data byte from the master
// ST_WRITE_ACK | holding data ACK low through the 9th clock
// ST_READ      | driving a data byte to the master, MSB first
// ST_READ_ACK  | sampling the master's ACK/NACK on the 9th clock
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0000111
) (
  input  logic       i_clk,
  input  logic       i_rst,
  inout  wire        io_scl,
  inout  wire        io_sda,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_req,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       full_q, full_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign io_sda = sda_oe_q ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so leaving reset never looks
  // like a bus condition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], io_scl};
      sda_sync_q <= {sda_sync_q[0], io_sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // Require SCL high on both samples so an SDA move that coincides with an
  // SCL edge is never taken as a bus condition.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    full_d     = full_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;

        // The counter wraps to 0 on the 8th rise, so full_q marks a complete
        // byte and keeps the START's own SCL fall from being taken as the
        // 8th falling edge.
        ST_ADDR, ST_WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              full_d = 1'b1;
              if (state_q == ST_WRITE) begin
                rx_byte_d  = {shift_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ST_WRITE) begin
              sda_oe_d = 1'b1;
              state_d  = ST_WRITE_ACK;
            end else if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        // shift_q[0] still holds R/W here; it is only overwritten on load.
        ST_ADDR_ACK: begin
          if (scl_rise && shift_q[0]) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            cnt_d = 3'd0;
            if (shift_q[0]) begin
              shift_d  = i_tx_byte;
              sda_oe_d = ~i_tx_byte[7];
              state_d  = ST_READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WRITE;
            end
          end
        end

        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
          end
        end

        // MSB is already on the bus at entry; falls 1..7 present bits 6..0
        // and the 8th releases the line for the master's ACK.
        ST_READ: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = ST_READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end

        // NACK drops to IDLE with o_busy still set; only STOP/START clear it.
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_IDLE;
            else       tx_req_d = 1'b1;
          end else if (scl_fall) begin
            shift_d  = i_tx_byte;
            sda_oe_d = ~i_tx_byte[7];
            cnt_d    = 3'd0;
            state_d  = ST_READ;
          end
        end

        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      full_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      full_q     <= full_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  assign o_rx_byte  = rx_byte_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_req   = tx_req_q;
  assign o_busy     = busy_q;

endmodule
